ifetch_ctrl: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the fetch/decode stage.
- Owns the architectural fetch PC and issues single-outstanding requests on the instruction bus.
- Buffers the returned 32-bit instruction and presents {pc, raw_instr, stall} to the fetch stage.
- Handles backpressure from the pipeline and PC redirects (branch, trap, xret), including discard of in-flight responses.

---
 rtl/ifetch_ctrl_pkg.sv | 37 +++
 rtl/ifetch_ctrl_if.sv | 26 ++
 rtl/ifetch_ctrl.sv | 126 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, fetch-stage
// output bundle and instruction-bus request/response shapes.
package ifetch_ctrl_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT    = 64'h0000_0000_8000_0000;
  localparam int unsigned INSTR_BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    FLUSH
  } ifetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;
    logic        misalign;
  } ifetch_out_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction bus between the fetch controller (master) and the memory side (slave).
interface ifetch_ctrl_if;

  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );

endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch front end: owns the fetch PC, keeps one request outstanding on the
// instruction bus and buffers the returned word for the fetch stage.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  ifetch_ctrl_if.master       ibus,
  input  logic                redirect_valid,
  input  logic [63:0]         redirect_pc,
  input  logic                stall,
  output logic [63:0]         instr_pc,
  output logic [31:0]         instr_raw,
  output logic                instr_valid,
  output logic                fetch_stall,
  output logic                instr_misalign
);

  ifetch_state_t state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [31:0]   buf_q, buf_d;

  ibus_resp_t    resp;
  ibus_req_t     req;
  ifetch_out_t   fetch_out;
  logic          misaligned;
  logic          req_fire;
  logic          accepted;

  assign resp = '{addr_ok: ibus.iresp_addr_ok,
                  data_ok: ibus.iresp_data_ok,
                  data:    ibus.iresp_data};

  assign misaligned = is_misaligned(pc_q[1:0]);
  assign req_fire   = (state_q == REQ) && !misaligned;
  assign accepted   = req_fire && resp.addr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // A redirect always wins; if a request is still in flight we park in FLUSH
  // so its response is swallowed instead of being mistaken for the new target.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    case (state_q)
      REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = (accepted && !resp.data_ok) ? FLUSH : REQ;
        end else if (misaligned) begin
          buf_d   = '0;
          state_d = HOLD;
        end else if (accepted) begin
          if (resp.data_ok) begin
            buf_d   = resp.data;
            state_d = HOLD;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = resp.data_ok ? REQ : FLUSH;
        end else if (resp.data_ok) begin
          buf_d   = resp.data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          buf_d   = '0;
          state_d = REQ;
        end else if (!stall) begin
          pc_d    = pc_q + 64'(INSTR_BYTES);
          state_d = REQ;
        end
      end
      FLUSH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (resp.data_ok) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // Outputs decode from state only; reset forces them quiet in its own cycle.
  always_comb begin
    req.valid          = !reset && req_fire;
    req.addr           = reset ? '0 : pc_q;
    fetch_out.valid    = !reset && (state_q == HOLD);
    fetch_out.pc       = fetch_out.valid ? pc_q : '0;
    fetch_out.raw_instr = (fetch_out.valid && !misaligned) ? buf_q : '0;
    fetch_out.misalign = fetch_out.valid && misaligned;
  end

  assign ibus.ireq_valid = req.valid;
  assign ibus.ireq_addr  = req.addr;

  assign instr_pc       = fetch_out.pc;
  assign instr_raw      = fetch_out.raw_instr;
  assign instr_valid    = fetch_out.valid;
  assign instr_misalign = fetch_out.misalign;
  assign fetch_stall    = !fetch_out.valid;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed cycle-exact scenarios followed by a random
// bus/pipeline phase scored against an architectural fetch-stream model.
module tb_ifetch_ctrl;
  import ifetch_ctrl_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic [63:0] instr_pc;
  logic [31:0] instr_raw;
  logic        instr_valid;
  logic        fetch_stall;
  logic        instr_misalign;

  int testsRun    = 0;
  int testsFailed = 0;
  bit sawDeadbeef = 1'b0;

  ifetch_ctrl_if bus ();

  ifetch_ctrl #(
    .RESET_PC   (RST_PC),
    .INSTR_BYTES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ibus          (bus.master),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .instr_pc      (instr_pc),
    .instr_raw     (instr_raw),
    .instr_valid   (instr_valid),
    .fetch_stall   (fetch_stall),
    .instr_misalign(instr_misalign)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (instr_valid && instr_raw == 32'hDEAD_BEEF) sawDeadbeef = 1'b1;
  end

  // Memory image seen by the random phase; never yields 32'hDEADBEEF.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    return {a[29:2] ^ 28'h5A5_A5A5, 4'h3};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic addrOk, input logic dataOk,
                               input logic [31:0] data, input logic redir,
                               input logic [63:0] redirPc, input logic stl);
    bus.iresp_addr_ok = addrOk;
    bus.iresp_data_ok = dataOk;
    bus.iresp_data    = data;
    redirect_valid    = redir;
    redirect_pc       = redirPc;
    stall             = stl;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] expPc;
    logic [63:0] busAddr;
    logic [63:0] rpc;
    logic        busPending;
    int          busCnt;
    int          consumed;
    logic        addrOk, dataOk, redir, stl;
    logic [31:0] data;
    logic        expMis;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    checkOutput("rst_ireq_valid", bus.ireq_valid, 0);
    checkOutput("rst_ireq_addr", bus.ireq_addr, 0);
    checkOutput("rst_instr_valid", instr_valid, 0);
    checkOutput("rst_instr_raw", instr_raw, 0);
    checkOutput("rst_instr_pc", instr_pc, 0);
    checkOutput("rst_misalign", instr_misalign, 0);
    checkOutput("rst_fetch_stall", fetch_stall, 1);

    // Zero-wait bus after reset release
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h0000_0013, 1'b0, 64'h0, 1'b0);
    #1;
    checkOutput("t1_ireq_valid", bus.ireq_valid, 1);
    checkOutput("t1_ireq_addr", bus.ireq_addr, RST_PC);
    checkOutput("t1_instr_valid_pre", instr_valid, 0);
    tick();
    checkOutput("t1_instr_valid", instr_valid, 1);
    checkOutput("t1_instr_raw", instr_raw, 32'h0000_0013);
    checkOutput("t1_instr_pc", instr_pc, RST_PC);
    checkOutput("t1_fetch_stall", fetch_stall, 0);
    checkOutput("t1_ireq_hold", bus.ireq_valid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("t1_next_addr", bus.ireq_addr, 64'h8000_0004);
    checkOutput("t1_next_valid", bus.ireq_valid, 1);
    checkOutput("t1_next_instr_valid", instr_valid, 0);

    // Three-cycle response delay, then four stalled cycles in HOLD
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("t2_wait_ireq", bus.ireq_valid, 0);
    checkOutput("t2_wait_valid", instr_valid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("t2_wait2_valid", instr_valid, 0);
    applyStimulus(1'b0, 1'b1, 32'h0051_0513, 1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_hold_valid", instr_valid, 1);
      checkOutput("t2_hold_pc", instr_pc, 64'h8000_0004);
      checkOutput("t2_hold_raw", instr_raw, 32'h0051_0513);
      checkOutput("t2_hold_fetch_stall", fetch_stall, 0);
      checkOutput("t2_hold_ireq", bus.ireq_valid, 0);
      tick();
    end
    checkOutput("t2_still_hold", instr_valid, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("t2_next_addr", bus.ireq_addr, 64'h8000_0008);
    checkOutput("t2_next_valid", bus.ireq_valid, 1);

    // Redirect while waiting; the stale response must be dropped
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_1000, 1'b0);
    tick();
    checkOutput("t3_flush_ireq", bus.ireq_valid, 0);
    checkOutput("t3_flush_valid", instr_valid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("t3_flush2_ireq", bus.ireq_valid, 0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("t3_req_addr", bus.ireq_addr, 64'h8000_1000);
    checkOutput("t3_req_valid", bus.ireq_valid, 1);
    checkOutput("t3_instr_valid", instr_valid, 0);

    // Redirect in HOLD together with stall=0
    applyStimulus(1'b1, 1'b1, 32'h0000_0093, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("t4_hold_valid", instr_valid, 1);
    checkOutput("t4_hold_pc", instr_pc, 64'h8000_1000);
    checkOutput("t4_hold_raw", instr_raw, 32'h0000_0093);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_2000, 1'b0);
    tick();
    checkOutput("t4_instr_valid", instr_valid, 0);
    checkOutput("t4_req_addr", bus.ireq_addr, 64'h8000_2000);
    checkOutput("t4_req_valid", bus.ireq_valid, 1);

    // Misaligned redirect target
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_0002, 1'b0);
    tick();
    checkOutput("t5_no_req", bus.ireq_valid, 0);
    checkOutput("t5_pre_valid", instr_valid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("t5_valid", instr_valid, 1);
    checkOutput("t5_misalign", instr_misalign, 1);
    checkOutput("t5_raw", instr_raw, 0);
    checkOutput("t5_pc", instr_pc, 64'h8000_0002);
    checkOutput("t5_hold_ireq", bus.ireq_valid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_3000, 1'b1);
    tick();
    checkOutput("t5_redir_addr", bus.ireq_addr, 64'h8000_3000);
    checkOutput("t5_redir_valid", instr_valid, 0);
    checkOutput("t5_redir_misalign", instr_misalign, 0);

    // Reset while a request is outstanding
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("t6_wait_ireq", bus.ireq_valid, 0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    #1;
    checkOutput("t6_rst_fetch_stall", fetch_stall, 1);
    checkOutput("t6_rst_ireq", bus.ireq_valid, 0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t6_addr", bus.ireq_addr, RST_PC);
    checkOutput("t6_ireq", bus.ireq_valid, 1);
    checkOutput("t6_instr_valid", instr_valid, 0);
    checkOutput("no_deadbeef", sawDeadbeef, 0);

    // Random phase: DUT must deliver the architectural fetch stream
    expPc      = RST_PC;
    busPending = 1'b0;
    busAddr    = '0;
    busCnt     = 0;
    consumed   = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checkOutput("fetch_stall_inv", fetch_stall, !instr_valid);
      addrOk = 1'b0;
      dataOk = 1'b0;
      data   = $urandom;
      if (busPending) checkOutput("single_outstanding", bus.ireq_valid, 0);
      if (bus.ireq_valid) begin
        checkOutput("req_addr", bus.ireq_addr, expPc);
        checkOutput("req_not_with_instr", instr_valid, 0);
      end
      if (bus.ireq_valid && !busPending && $urandom_range(0, 2) != 0) begin
        addrOk = 1'b1;
        busCnt = $urandom_range(0, 2);
        if (busCnt == 0) begin
          dataOk = 1'b1;
          data   = memWord(bus.ireq_addr);
        end else begin
          busPending = 1'b1;
          busAddr    = bus.ireq_addr;
        end
      end else if (busPending) begin
        busCnt--;
        if (busCnt == 0) begin
          dataOk     = 1'b1;
          data       = memWord(busAddr);
          busPending = 1'b0;
        end
      end
      stl   = ($urandom_range(0, 2) == 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = 64'h8000_0000 | 64'({$urandom_range(0, 1023), 2'b00});
      if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'b10;
      if (instr_valid) begin
        expMis = (expPc[1:0] != 2'b00);
        checkOutput("stream_pc", instr_pc, expPc);
        checkOutput("stream_misalign", instr_misalign, expMis);
        checkOutput("stream_raw", instr_raw, expMis ? 32'h0 : memWord(expPc));
        if (!redir && !stl) begin
          expPc = expPc + 64'd4;
          consumed++;
        end
      end else begin
        checkOutput("raw_zero_invalid", instr_raw, 0);
      end
      if (redir) expPc = rpc;
      applyStimulus(addrOk, dataOk, data, redir, rpc, stl);
      tick();
    end
    checkOutput("progress", consumed >= 200, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
